multi_ch_clk_divider: RTL and testbench

- N-channel programmable clock divider for the processor and valve-timing logic.
- Each channel produces a 50 %-duty divided square wave from clk_100m, plus a one-cycle tick strobe that is synchronous to clk_100m.
- Half-period per channel is runtime-programmable through a write port; updates are applied glitch-free at the channel's next toggle.
- A global sync input phase-aligns all enabled channels.

---
 rtl/clkdiv_pkg.sv | 14 +
 rtl/clkdiv_channel.sv | 86 ++++++++
 rtl/multi_ch_clk_divider.sv | 45 ++++
 tb/tb_multi_ch_clk_divider.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants for the multi-channel clock divider.
// Half-periods are expressed in clk_100m cycles.
package clkdiv_pkg;

    localparam int CLK_100M_HZ       = 100_000_000;
    localparam int DEFAULT_HALF_50HZ = 1_000_000;
    localparam int DEFAULT_HALF_1KHZ = 50_000;

    // Half-period in clk_100m cycles for a requested output frequency.
    function automatic int half_for_hz(input int hz);
        return CLK_100M_HZ / (2 * hz);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/pending half-period, toggle and tick.
// Pending half-periods are applied only on the wrap cycle, or at once when idle or on sync.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W        = 20,
    parameter int DEFAULT_HALF = DEFAULT_HALF_50HZ
) (
    input  logic             clk_100m,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] half, half_nxt;
    logic [CNT_W-1:0] pend_half, pend_half_nxt;
    logic             clk_nxt, tick_nxt, pend_nxt;
    logic             apply;
    logic             wrap;

    assign wrap = (half != '0) && (count == half - ONE);

    always_comb begin
        count_nxt = count;
        clk_nxt   = clk_out;
        tick_nxt  = 1'b0;
        apply     = 1'b0;

        // A zero half-period behaves exactly like a disabled channel.
        if (!en || (half == '0)) begin
            count_nxt = '0;
            clk_nxt   = 1'b0;
            apply     = 1'b1;
        end else if (sync) begin
            count_nxt = '0;
            clk_nxt   = 1'b0;
            apply     = 1'b1;
        end else if (wrap) begin
            count_nxt = '0;
            clk_nxt   = ~clk_out;
            tick_nxt  = ~clk_out;
            apply     = 1'b1;
        end else begin
            count_nxt = count + ONE;
        end

        half_nxt      = (apply && pend) ? pend_half : half;
        pend_half_nxt = wr ? wr_half : pend_half;

        // A write in the apply cycle stays pending for the next opportunity.
        if (wr) begin
            pend_nxt = 1'b1;
        end else if (apply) begin
            pend_nxt = 1'b0;
        end else begin
            pend_nxt = pend;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            half      <= CNT_W'(DEFAULT_HALF);
            pend_half <= '0;
            pend      <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            count     <= count_nxt;
            half      <= half_nxt;
            pend_half <= pend_half_nxt;
            pend      <= pend_nxt;
            clk_out   <= clk_nxt;
            tick      <= tick_nxt;
        end
    end

endmodule

// File: rtl/multi_ch_clk_divider.sv
// N-channel programmable clock divider: decodes configuration writes and fans
// enable and sync out to one clkdiv_channel per output.
module multi_ch_clk_divider
    import clkdiv_pkg::*;
#(
    parameter int   N_CH         = 4,
    parameter int   CNT_W        = 20,
    parameter int   DEFAULT_HALF = DEFAULT_HALF_50HZ,
    localparam int  CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_100m,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en_i,
    input  logic             sync_i,
    input  logic             cfg_we_i,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [CNT_W-1:0] cfg_half_i,
    output logic [N_CH-1:0]  clk_o,
    output logic [N_CH-1:0]  tick_o,
    output logic [N_CH-1:0]  pend_o
);

    // Channel indices at or above N_CH match no channel, so such writes vanish.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr;

        assign wr = cfg_we_i && (cfg_ch_i == CH_W'(i));

        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk_100m (clk_100m),
            .rst_n    (rst_n),
            .en       (en_i[i]),
            .sync     (sync_i),
            .wr       (wr),
            .wr_half  (cfg_half_i),
            .clk_out  (clk_o[i]),
            .tick     (tick_o[i]),
            .pend     (pend_o[i])
        );
    end

endmodule

// File: tb/tb_multi_ch_clk_divider.sv
// Self-checking bench for multi_ch_clk_divider: a per-cycle reference model
// feeds a scoreboard queue, plus directed anchor checks at key edges.
module tb_multi_ch_clk_divider;

    localparam int N_CH  = 6;
    localparam int CNT_W = 20;
    localparam int DEF   = 20;
    localparam int CH_W  = 3;

    logic              clk_100m   = 1'b0;
    logic              rst_n      = 1'b0;
    logic [N_CH-1:0]   en_i       = '0;
    logic              sync_i     = 1'b0;
    logic              cfg_we_i   = 1'b0;
    logic [CH_W-1:0]   cfg_ch_i   = '0;
    logic [CNT_W-1:0]  cfg_half_i = '0;
    logic [N_CH-1:0]   clk_o;
    logic [N_CH-1:0]   tick_o;
    logic [N_CH-1:0]   pend_o;

    always #5 clk_100m = ~clk_100m;

    // Six channels so that channel selects 6 and 7 are out of range.
    multi_ch_clk_divider #(
        .N_CH         (N_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEF)
    ) dut (
        .clk_100m   (clk_100m),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .sync_i     (sync_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_ch_i   (cfg_ch_i),
        .cfg_half_i (cfg_half_i),
        .clk_o      (clk_o),
        .tick_o     (tick_o),
        .pend_o     (pend_o)
    );

    typedef struct packed {
        logic [N_CH-1:0] clk;
        logic [N_CH-1:0] tick;
        logic [N_CH-1:0] pend;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [CNT_W-1:0] m_half      [N_CH];
    logic [CNT_W-1:0] m_pend_half [N_CH];
    logic [CNT_W-1:0] m_left      [N_CH];
    logic             m_pend      [N_CH];
    logic             m_clk       [N_CH];
    logic             m_tick      [N_CH];

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            m_half[ch]      = CNT_W'(DEF);
            m_pend_half[ch] = '0;
            m_left[ch]      = CNT_W'(DEF);
            m_pend[ch]      = 1'b0;
            m_clk[ch]       = 1'b0;
            m_tick[ch]      = 1'b0;
        end
    endtask

    // m_left counts the edges still to go before the next toggle.
    task automatic model_step();
        exp_t e;
        for (int ch = 0; ch < N_CH; ch++) begin
            logic wr;
            logic applied;
            wr      = cfg_we_i && (int'(cfg_ch_i) == ch);
            applied = 1'b0;
            m_tick[ch] = 1'b0;
            if (!en_i[ch] || (m_half[ch] == '0) || sync_i) begin
                m_clk[ch] = 1'b0;
                applied   = 1'b1;
            end else if (m_left[ch] == CNT_W'(1)) begin
                m_clk[ch]  = ~m_clk[ch];
                m_tick[ch] = m_clk[ch];
                applied    = 1'b1;
            end else begin
                m_left[ch] = m_left[ch] - CNT_W'(1);
            end
            if (applied) begin
                if (m_pend[ch]) m_half[ch] = m_pend_half[ch];
                m_pend[ch] = 1'b0;
                m_left[ch] = m_half[ch];
            end
            if (wr) begin
                m_pend[ch]      = 1'b1;
                m_pend_half[ch] = cfg_half_i;
            end
            e.clk[ch]  = m_clk[ch];
            e.tick[ch] = m_tick[ch];
            e.pend[ch] = m_pend[ch];
        end
        sb_q.push_back(e);
    endtask

    task automatic check_vec(input string tag, input logic [N_CH-1:0] obs,
                             input logic [N_CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0 entries expected=1 entry");
        end else begin
            e = sb_q.pop_front();
            check_vec("sb_clk_o", clk_o, e.clk);
            check_vec("sb_tick_o", tick_o, e.tick);
            check_vec("sb_pend_o", pend_o, e.pend);
        end
    endtask

    // Drives one cycle of inputs, predicts it, clocks it and compares #1 later.
    task automatic applyStimulus(input logic [N_CH-1:0] en, input logic sync,
                                 input logic we, input logic [CH_W-1:0] ch,
                                 input logic [CNT_W-1:0] half);
        en_i       = en;
        sync_i     = sync;
        cfg_we_i   = we;
        cfg_ch_i   = ch;
        cfg_half_i = half;
        model_step();
        @(posedge clk_100m);
        #1;
        checkOutput();
        sync_i   = 1'b0;
        cfg_we_i = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(en_i, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        $display("[TB] start");
        model_reset();
        #12;
        check_vec("reset_clk_o", clk_o, '0);
        check_vec("reset_tick_o", tick_o, '0);
        check_vec("reset_pend_o", pend_o, '0);
        @(negedge clk_100m);
        rst_n = 1'b1;
        run_cycles(2);

        // Default half-period on channel 0 only.
        applyStimulus(6'b000001, 1'b0, 1'b0, '0, '0);
        run_cycles(18);
        check_bit("t1_pre_rise", clk_o[0], 1'b0);
        run_cycles(1);
        check_bit("t1_rise_clk", clk_o[0], 1'b1);
        check_bit("t1_rise_tick", tick_o[0], 1'b1);
        check_vec("t1_others", clk_o & 6'b111110, '0);
        run_cycles(1);
        check_bit("t1_tick_width", tick_o[0], 1'b0);
        run_cycles(19);
        check_bit("t1_fall", clk_o[0], 1'b0);
        run_cycles(20);
        check_bit("t1_period_tick", tick_o[0], 1'b1);

        // Channel 1 half=3, then rewrite to 5 during the high phase.
        applyStimulus(6'b000001, 1'b0, 1'b1, 3'd1, 20'd3);
        check_bit("t2_pend_set", pend_o[1], 1'b1);
        applyStimulus(6'b000001, 1'b0, 1'b0, '0, '0);
        check_bit("t2_pend_idle_apply", pend_o[1], 1'b0);
        applyStimulus(6'b000011, 1'b0, 1'b0, '0, '0);
        run_cycles(2);
        check_bit("t2_rise", clk_o[1], 1'b1);
        check_bit("t2_rise_tick", tick_o[1], 1'b1);
        applyStimulus(6'b000011, 1'b0, 1'b1, 3'd1, 20'd5);
        check_bit("t2_repend", pend_o[1], 1'b1);
        run_cycles(1);
        check_bit("t2_high_hold", clk_o[1], 1'b1);
        check_bit("t2_pend_hold", pend_o[1], 1'b1);
        run_cycles(1);
        check_bit("t2_wrap_fall", clk_o[1], 1'b0);
        check_bit("t2_pend_clear", pend_o[1], 1'b0);
        run_cycles(4);
        check_bit("t2_long_low", clk_o[1], 1'b0);
        run_cycles(1);
        check_bit("t2_new_rise", clk_o[1], 1'b1);

        // Channels 0 and 2 out of phase, then sync with a same-cycle write.
        applyStimulus(6'b000000, 1'b0, 1'b1, 3'd0, 20'd3);
        applyStimulus(6'b000000, 1'b0, 1'b1, 3'd2, 20'd4);
        run_cycles(1);
        applyStimulus(6'b000001, 1'b0, 1'b0, '0, '0);
        run_cycles(1);
        applyStimulus(6'b000101, 1'b0, 1'b0, '0, '0);
        run_cycles(5);
        applyStimulus(6'b000101, 1'b1, 1'b1, 3'd0, 20'd2);
        check_vec("t3_sync_clk", clk_o & 6'b000101, '0);
        check_bit("t3_sync_pend", pend_o[0], 1'b1);
        run_cycles(2);
        check_bit("t3_ch0_low", clk_o[0], 1'b0);
        run_cycles(1);
        check_bit("t3_ch0_rise", tick_o[0], 1'b1);
        check_bit("t3_ch2_low", clk_o[2], 1'b0);
        check_bit("t3_pend_landed", pend_o[0], 1'b0);
        run_cycles(1);
        check_bit("t3_ch2_rise", tick_o[2], 1'b1);
        run_cycles(1);
        check_bit("t3_ch0_newhalf", clk_o[0], 1'b0);

        // Out-of-range writes, then half=0 on channel 2.
        applyStimulus(6'b000101, 1'b0, 1'b1, 3'd6, 20'd7);
        check_vec("t4_bad_ch6", pend_o, '0);
        applyStimulus(6'b000101, 1'b0, 1'b1, 3'd7, 20'd7);
        check_vec("t4_bad_ch7", pend_o, '0);
        applyStimulus(6'b000001, 1'b0, 1'b1, 3'd2, 20'd0);
        run_cycles(1);
        applyStimulus(6'b000101, 1'b0, 1'b0, '0, '0);
        run_cycles(8);
        check_bit("t4_half0_clk", clk_o[2], 1'b0);

        // Async reset while ch0 is high and ch1 has a pending write.
        applyStimulus(6'b000111, 1'b0, 1'b1, 3'd1, 20'd9);
        for (int k = 0; k < 4 && !m_clk[0]; k++) run_cycles(1);
        check_bit("t5_pre_ch0_high", clk_o[0], 1'b1);
        check_bit("t5_pre_ch1_pend", pend_o[1], 1'b1);
        #2;
        rst_n = 1'b0;
        en_i  = '0;
        #1;
        check_vec("t5_async_clk", clk_o, '0);
        check_vec("t5_async_tick", tick_o, '0);
        check_vec("t5_async_pend", pend_o, '0);
        sb_q.delete();
        model_reset();
        @(negedge clk_100m);
        rst_n = 1'b1;

        // Default half restored on ch3; drop while high, re-enable with half=2.
        applyStimulus(6'b001000, 1'b0, 1'b0, '0, '0);
        run_cycles(18);
        check_bit("t6_pre_rise", clk_o[3], 1'b0);
        run_cycles(1);
        check_bit("t6_default_rise", clk_o[3], 1'b1);
        run_cycles(3);
        applyStimulus(6'b000000, 1'b0, 1'b1, 3'd3, 20'd2);
        check_bit("t6_drop", clk_o[3], 1'b0);
        run_cycles(9);
        check_bit("t6_disabled", clk_o[3], 1'b0);
        applyStimulus(6'b001000, 1'b0, 1'b0, '0, '0);
        check_bit("t6_reen_low", clk_o[3], 1'b0);
        run_cycles(1);
        check_bit("t6_reen_rise", tick_o[3], 1'b1);
        run_cycles(2);
        check_bit("t6_fall", clk_o[3], 1'b0);
        run_cycles(2);
        check_bit("t6_period4", tick_o[3], 1'b1);
        run_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
